// File: rtl/iob_cpu_bus_router.sv
// Routes PicoRV32 native-interface accesses to one of 2**SEL_W slave buses, allowing
// one outstanding transaction and timing out silent slaves with an error word.
module iob_cpu_bus_router #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       SEL_W      = 2,
    parameter int unsigned       BOOT_SLAVE = 1,
    parameter int unsigned       TIMEOUT_W  = 8,
    parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         boot,
    input  logic                         cpu_valid,
    input  logic                         cpu_instr,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic [DATA_W/8-1:0]          cpu_wstrb,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic [(2**SEL_W)-1:0]        s_valid,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [(2**SEL_W)*DATA_W-1:0] s_rdata,
    input  logic [(2**SEL_W)-1:0]        s_ready,
    input  logic                         err_clr,
    output logic                         err,
    output logic [ADDR_W-1:0]            err_addr
);
    localparam int unsigned      NS       = 2**SEL_W;
    localparam logic [SEL_W-1:0] BOOT_SEL = SEL_W'(BOOT_SLAVE);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state, state_next;
    logic [SEL_W-1:0]    sel, sel_next;
    logic [TIMEOUT_W-1:0] timer;
    logic                sel_ready;
    logic                timer_max;
    logic                timed_out;
    logic                is_read;
    logic [DATA_W-1:0]   sel_rdata;

    always_comb begin
        sel_next = cpu_addr[ADDR_W-1 -: SEL_W];
        if (cpu_instr) begin
            sel_next = boot ? BOOT_SEL : '0;
        end
        sel_ready = s_ready[sel];
        sel_rdata = s_rdata[sel*DATA_W +: DATA_W];
        timer_max = (timer == '1);
        // Ready beats a simultaneous timeout, so only a silent slave can raise err.
        timed_out = (state == REQ) && !sel_ready && timer_max;
        is_read   = (s_wstrb == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cpu_valid) state_next = REQ;
            REQ:     if (sel_ready || timer_max) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cpu_ready is registered on entry to RESP so it is high exactly while in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel       <= '0;
            timer     <= '0;
            s_valid   <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            err_addr  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        s_addr  <= cpu_addr;
                        s_wdata <= cpu_wdata;
                        s_wstrb <= cpu_wstrb;
                        sel     <= sel_next;
                        s_valid <= NS'(1) << sel_next;
                        timer   <= '0;
                    end
                end
                REQ: begin
                    if (sel_ready) begin
                        s_valid   <= '0;
                        cpu_ready <= 1'b1;
                        cpu_rdata <= is_read ? sel_rdata : '0;
                    end else if (timer_max) begin
                        s_valid   <= '0;
                        cpu_ready <= 1'b1;
                        cpu_rdata <= is_read ? ERR_DATA : '0;
                        err_addr  <= s_addr;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (timed_out) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: doc/iob_cpu_bus_router.md
Name: iob_cpu_bus_router

Overview:
- Parametrised successor to the single-split CPU wrapper: takes the PicoRV32 native memory interface and routes each access to one of 2**SEL_W slave buses.
- Instruction fetches go to a boot-dependent slave; data accesses are decoded from the top address bits.
- Registers the request, enforces a one-outstanding-transaction handshake and times out unresponsive slaves with an error word and a sticky error flag.
- Sits between the CPU core and the system interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- SEL_W, 2, slave-select bits; number of slaves NS = 2**SEL_W, legal SEL_W 1..3.
- BOOT_SLAVE, 1, slave index that receives instruction fetches while boot=1.
- TIMEOUT_W, 8, timeout counter width; timeout fires after 2**TIMEOUT_W-1 REQ cycles.
- ERR_DATA, 32'hDEADBEEF, rdata returned on a timed-out read.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- boot  in  1  boot mode, sampled at request capture
- cpu_valid  in  1  CPU request valid
- cpu_instr  in  1  request is an instruction fetch
- cpu_addr  in  ADDR_W  request address
- cpu_wdata  in  DATA_W  write data
- cpu_wstrb  in  DATA_W/8  byte strobes; all zero means read
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- s_valid  out  NS  per-slave request valid, one-hot or zero
- s_addr  out  ADDR_W  shared registered address
- s_wdata  out  DATA_W  shared registered write data
- s_wstrb  out  DATA_W/8  shared registered strobes
- s_rdata  in  NS*DATA_W  slave read data; slave k occupies bits [k*DATA_W +: DATA_W]
- s_ready  in  NS  per-slave ready
- err_clr  in  1  clears err
- err  out  1  sticky timeout flag
- err_addr  out  ADDR_W  address of the most recent timed-out access

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE; s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0; cpu_ready=0, cpu_rdata=0; err=0, err_addr=0; timer=0.
- FSM states: IDLE, REQ, RESP.
- IDLE (cpu_ready=0, s_valid=0), when cpu_valid=1:
  - Latch addr, wdata and wstrb.
  - Compute sel: if cpu_instr, sel = BOOT_SLAVE when boot=1, else 0; otherwise sel = cpu_addr[ADDR_W-1 -: SEL_W].
  - Clear timer and go to REQ.
- REQ:
  - s_valid[sel]=1 (registered); all other bits 0; s_addr, s_wdata and s_wstrb come from the latched values.
  - If s_ready[sel]=1: load rdata_reg with s_rdata[sel] for reads, or 0 for writes; go to RESP.
  - Else if timer == 2**TIMEOUT_W-1: load rdata_reg with ERR_DATA for reads, or 0 for writes; set err; load err_addr; go to RESP.
  - Else timer increments.
  - s_ready from non-selected slaves is ignored.
  - If ready and timeout coincide, ready wins: no error.
- RESP:
  - cpu_ready=1 for exactly one cycle; cpu_rdata=rdata_reg; s_valid=0; next state IDLE.
  - cpu_rdata holds its value after RESP until the next RESP.
- Latency: cpu_valid sampled at cycle 0, s_valid high at cycle 1. If s_ready arrives at cycle 1, cpu_ready is high at cycle 2. Minimum CPU latency is 2 cycles; back-to-back accesses take 3 cycles each.
- cpu_valid falling during REQ or RESP is ignored; the transaction completes. Inputs are re-sampled only in IDLE.
- A boot change mid-transaction does not affect the in-flight transaction.
- err_clr=1 clears err; if a timeout sets err in the same cycle, set wins. err_addr is not cleared by err_clr.
- rst asserted in any state returns to the reset values on the next edge; no cpu_ready pulse is emitted for the aborted access.
- sel is never out of range: it is SEL_W bits wide and NS = 2**SEL_W.

Test Plan:
- Data read, SEL_W=2, addr 0x8000_0010 (sel=2), slave 2 ready at cycle 1 with rdata 0x1234_5678 -> s_valid=4'b0100 at cycle 1, cpu_ready at cycle 2 with cpu_rdata=0x1234_5678, err=0.
- Fetch at addr 0x0000_0100 with boot=1, then boot=0 -> first fetch asserts s_valid=4'b0010 (BOOT_SLAVE=1), second asserts s_valid=4'b0001; each completes with the slave's rdata.
- Write addr 0xC000_0004, wdata 0xA5A5_A5A5, wstrb 4'b0011, slave 3 ready after 5 cycles -> s_wdata/s_wstrb stable through REQ, cpu_ready exactly once, cpu_rdata=0.
- Read to slave 1 with no ready, TIMEOUT_W=4 -> after 15 REQ cycles cpu_ready=1 with cpu_rdata=0xDEADBEEF, err=1, err_addr=request addr. err_clr pulse -> err=0; err_clr in the same cycle as a new timeout -> err stays 1.
- Ready and timeout in the same cycle, plus a spurious s_ready on a non-selected slave -> slave data returned, err unchanged, spurious ready has no effect.
- rst asserted during REQ -> next cycle s_valid=0, cpu_ready=0, state IDLE; a following read completes normally.
